iq_alloc_12_4: RTL and testbench
================================

# iq_alloc_12_4

Allocation and storage half of the 12-entry, 4-wide issue queue. Each cycle it accepts up to 4 dispatched 160-bit micro-ops and writes them, in lane order, into the lowest-indexed free entries. It holds the entries and their valid bits, and presents them to the 12-to-4 select arbiter. It frees entries when the arbiter's grants come back, and clears everything on a pipeline flush.

## Interface
Parameters:
- DW, 160, entry payload width
- N, 12, queue entries
- W, 4, dispatch lanes per cycle

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  clears every entry this edge; overrides dispatch and grant
- in_data0..in_data3  input  DW each  dispatch payloads, lanes 0..3
- in_valid  input  W  per-lane valid; any pattern, need not be contiguous
- in_ready  output  1  high when free_cnt >= W and flush is low
- issue_grant  input  N  bit i frees entry i at this edge
- entry_data0..entry_data11  output  DW each  registered entry payloads
- entry_valid  output  N  registered occupancy; bit i = entry i
- free_cnt  output  4  number of zero bits in entry_valid, 0..12
- alloc_mask  output  N  entries written at this edge (combinational, for debug/verification)

## Operation
- Dispatch fires when in_ready is high and in_valid is nonzero. There is no partial acceptance.
  - When in_ready is low, the whole lane group is ignored. Upstream holds the group.
- Free set = ~entry_valid as registered at the start of the cycle. Grants arriving this cycle do not enlarge the free set.
- Compaction:
  - The k-th set bit of in_valid (counted from lane 0) goes to the k-th lowest-indexed free entry.
  - Example: in_valid=4'b1010 with free entries {2,5,7,...} sends lane1→2 and lane3→5.
- alloc_mask marks exactly the popcount(in_valid) lowest free entries when dispatch fires. Otherwise it is 0.
- Write: entry_data[e] <= chosen lane payload and entry_valid[e] <= 1 for every e in alloc_mask.
- Grant: entry_valid[i] <= 0 for every i with issue_grant[i]=1.
  - A grant on an already-invalid entry is ignored.
  - entry_data is not cleared on grant; stale data under valid=0 is permitted.
- No write/grant conflict can occur: a granted entry is valid, so it is never in the free set.
- Bit-order rule: the select arbiter's grant vector has MSB = entry 0. The top level bit-reverses that vector before driving issue_grant. Inside this block, bit i always means entry i.
- Flush: entry_valid <= 0. Same-cycle dispatch and grants are discarded. entry_data is held.
- Reset: entry_valid=0, all entry_data=0, free_cnt=12, in_ready=1, alloc_mask=0.
- free_cnt is the popcount of registered entry_valid. It is 4 bits wide, so 12 fits without wrap.

## Timing
- Dispatch to entry_valid high: 1 cycle. The entry is visible to the arbiter the cycle after the dispatch edge.
- Grant to entry free: takes effect at the grant edge. The entry may be reallocated in the following cycle.
- Minimum entry lifetime is 1 cycle: write at edge t, grant during cycle t+1, free after edge t+1.
- in_ready, free_cnt and alloc_mask are combinational from registered state plus in_valid/flush. There is no path from issue_grant to in_ready.
- Full boundary: free_cnt <= 3 forces in_ready=0, even when in_valid has fewer bits set than free entries.
- Empty boundary: free_cnt=12 with no dispatch holds; grants are ignored.
- rst and flush together: rst wins and also zeroes entry_data.

## Structure
- Package iq_pkg holds:
  - IQ_DW=160, IQ_N=12, IQ_W=4
  - typedef iq_entry_t (logic [IQ_DW-1:0])
  - typedef iq_mask_t (logic [IQ_N-1:0])
  - Shared with the select arbiter.
- Sub-module free_slot_pick: combinational. Takes a free mask (N) and a request count (0..W). Produces one-hot target entry per rank (W x N) and alloc_mask. Uses prefix-count selection from low index.
- Lane-to-rank mapping (prefix count of in_valid) and the entry registers stay in iq_alloc_12_4.

## Test plan
- Reset, then in_valid=4'b1111 with payloads A,B,C,D → next cycle entry_valid=12'h00F, entries 0..3 = A..D, free_cnt=8.
- Entries {0,1,3} valid, in_valid=4'b1010 with payloads X,Y → alloc_mask=12'h014, entry2=X, entry4=Y.
- Fill to 9 valid (free_cnt=3), in_valid=4'b0001 → in_ready=0, nothing written. Grant one entry → next cycle free_cnt=4, in_ready=1.
- Queue full (12 valid), issue_grant=12'h801 with in_valid=4'b1111 → no write that cycle. Next cycle entry_valid=12'h7FE, free_cnt=2, in_ready=0.
- Grant entry 5 at edge t, dispatch one lane in cycle t+1 with entries 0..4 valid → written to entry 5.
- flush with in_valid=4'b1111 and grants pending → entry_valid=0, free_cnt=12, no writes. rst asserted mid-fill → all entry_data=0.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared issue-queue types and sizes, used by the allocator and the select arbiter.
package iq_pkg;
    localparam int IQ_DW = 160;
    localparam int IQ_N  = 12;
    localparam int IQ_W  = 4;

    typedef logic [IQ_DW-1:0] iq_entry_t;
    typedef logic [IQ_N-1:0]  iq_mask_t;

    function automatic logic [3:0] popcnt_mask(iq_mask_t m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < IQ_N; i++) c = c + {3'b0, m[i]};
        return c;
    endfunction
endpackage

// File: rtl/free_slot_pick.sv
// Picks the lowest-indexed free entries: one-hot target per rank, plus the
// mask of entries actually claimed by req_cnt requests.
module free_slot_pick #(
    parameter int N = 12,
    parameter int W = 4
) (
    input  logic [N-1:0]              free_mask,
    input  logic [$clog2(W+1)-1:0]    req_cnt,
    output logic [W-1:0][N-1:0]       target,
    output logic [N-1:0]              alloc_mask
);
    localparam int CW = $clog2(N+1);
    localparam int RW = $clog2(W);

    logic [CW-1:0] rank;

    // rank = number of free entries strictly below e
    always_comb begin
        target     = '0;
        alloc_mask = '0;
        rank       = '0;
        for (int e = 0; e < N; e++) begin
            if (free_mask[e]) begin
                if (rank < CW'(W))       target[rank[RW-1:0]][e] = 1'b1;
                if (rank < CW'(req_cnt)) alloc_mask[e]           = 1'b1;
                rank = rank + 1'b1;
            end
        end
    end
endmodule

// File: rtl/iq_alloc_12_4.sv
// Issue-queue allocation/storage: compacts up to 4 dispatch lanes into the
// lowest free entries, frees on grant, clears on flush.
module iq_alloc_12_4
    import iq_pkg::*;
#(
    parameter int DW = IQ_DW,
    parameter int N  = IQ_N,
    parameter int W  = IQ_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] in_data0,
    input  logic [DW-1:0] in_data1,
    input  logic [DW-1:0] in_data2,
    input  logic [DW-1:0] in_data3,
    input  logic [W-1:0]  in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  issue_grant,
    output logic [DW-1:0] entry_data0,
    output logic [DW-1:0] entry_data1,
    output logic [DW-1:0] entry_data2,
    output logic [DW-1:0] entry_data3,
    output logic [DW-1:0] entry_data4,
    output logic [DW-1:0] entry_data5,
    output logic [DW-1:0] entry_data6,
    output logic [DW-1:0] entry_data7,
    output logic [DW-1:0] entry_data8,
    output logic [DW-1:0] entry_data9,
    output logic [DW-1:0] entry_data10,
    output logic [DW-1:0] entry_data11,
    output logic [N-1:0]  entry_valid,
    output logic [3:0]    free_cnt,
    output logic [N-1:0]  alloc_mask
);
    localparam int RW = $clog2(W);
    localparam int QW = $clog2(W+1);

    logic [W-1:0][DW-1:0] lane_data;
    logic [N-1:0][DW-1:0] data_q;
    logic [N-1:0]         valid_q;
    logic [W-1:0][RW-1:0] lane_rank;
    logic [QW-1:0]        lane_cnt;
    logic [QW-1:0]        req_cnt;
    logic                 fire;
    logic [W-1:0][N-1:0]  target;
    logic [W-1:0][DW-1:0] rank_data;
    logic [N-1:0][DW-1:0] wdata;

    assign lane_data[0] = in_data0;
    assign lane_data[1] = in_data1;
    assign lane_data[2] = in_data2;
    assign lane_data[3] = in_data3;

    assign entry_data0  = data_q[0];
    assign entry_data1  = data_q[1];
    assign entry_data2  = data_q[2];
    assign entry_data3  = data_q[3];
    assign entry_data4  = data_q[4];
    assign entry_data5  = data_q[5];
    assign entry_data6  = data_q[6];
    assign entry_data7  = data_q[7];
    assign entry_data8  = data_q[8];
    assign entry_data9  = data_q[9];
    assign entry_data10 = data_q[10];
    assign entry_data11 = data_q[11];
    assign entry_valid  = valid_q;

    assign free_cnt = 4'(N) - popcnt_mask(valid_q);
    assign in_ready = (free_cnt >= 4'(W)) && !flush;
    assign fire     = in_ready && (|in_valid);
    assign req_cnt  = fire ? lane_cnt : '0;

    // Lane rank = number of valid lanes below it; lane_cnt = total valid lanes.
    always_comb begin
        lane_rank = '0;
        lane_cnt  = '0;
        for (int l = 0; l < W; l++) begin
            lane_rank[l] = lane_cnt[RW-1:0];
            lane_cnt     = lane_cnt + {{(QW-1){1'b0}}, in_valid[l]};
        end
    end

    free_slot_pick #(.N(N), .W(W)) u_pick (
        .free_mask  (~valid_q),
        .req_cnt    (req_cnt),
        .target     (target),
        .alloc_mask (alloc_mask)
    );

    always_comb begin
        rank_data = '0;
        for (int r = 0; r < W; r++)
            for (int l = 0; l < W; l++)
                if (in_valid[l] && lane_rank[l] == RW'(r)) rank_data[r] = lane_data[l];
    end

    always_comb begin
        wdata = '0;
        for (int e = 0; e < N; e++)
            for (int r = 0; r < W; r++)
                if (target[r][e]) wdata[e] = wdata[e] | rank_data[r];
    end

    // Grant and write never hit the same entry: allocation only targets invalid entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q <= (valid_q & ~issue_grant) | alloc_mask;
            for (int e = 0; e < N; e++)
                if (alloc_mask[e]) data_q[e] <= wdata[e];
        end
    end
endmodule

// File: tb/tb_iq_alloc_12_4.sv
// Directed + short random bench for iq_alloc_12_4 with a reference model and
// an expected-state scoreboard.
module tb_iq_alloc_12_4;
    logic         clk = 1'b0;
    logic         rst, flush;
    logic [159:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]   in_valid;
    logic         in_ready;
    logic [11:0]  issue_grant, entry_valid, alloc_mask;
    logic [3:0]   free_cnt;
    logic [159:0] entry_data0, entry_data1, entry_data2, entry_data3;
    logic [159:0] entry_data4, entry_data5, entry_data6, entry_data7;
    logic [159:0] entry_data8, entry_data9, entry_data10, entry_data11;
    logic [159:0] ed [12];

    typedef struct {
        logic [11:0]        valid;
        logic [11:0][159:0] data;
        logic               chk_all;
    } exp_t;
    exp_t sbq[$];

    logic [11:0]        mvalid;
    logic [11:0][159:0] mdata;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iq_alloc_12_4 dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_valid(in_valid), .in_ready(in_ready), .issue_grant(issue_grant),
        .entry_data0(entry_data0), .entry_data1(entry_data1), .entry_data2(entry_data2),
        .entry_data3(entry_data3), .entry_data4(entry_data4), .entry_data5(entry_data5),
        .entry_data6(entry_data6), .entry_data7(entry_data7), .entry_data8(entry_data8),
        .entry_data9(entry_data9), .entry_data10(entry_data10), .entry_data11(entry_data11),
        .entry_valid(entry_valid), .free_cnt(free_cnt), .alloc_mask(alloc_mask)
    );

    assign ed[0] = entry_data0;  assign ed[1]  = entry_data1;  assign ed[2]  = entry_data2;
    assign ed[3] = entry_data3;  assign ed[4]  = entry_data4;  assign ed[5]  = entry_data5;
    assign ed[6] = entry_data6;  assign ed[7]  = entry_data7;  assign ed[8]  = entry_data8;
    assign ed[9] = entry_data9;  assign ed[10] = entry_data10; assign ed[11] = entry_data11;

    task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] rnd160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive at negedge, check combinational outputs, push the model's
    // post-edge state, then compare it after the edge.
    task automatic step(input logic r, input logic f, input logic [3:0] iv,
                        input logic [11:0] g, input logic [3:0][159:0] d);
        int           fl[$];
        int           k;
        int           nfree;
        logic         ready, fire;
        logic [11:0]  ealloc, nv;
        logic [11:0][159:0] nd;
        exp_t         e;

        @(negedge clk);
        rst = r; flush = f; in_valid = iv; issue_grant = g;
        in_data0 = d[0]; in_data1 = d[1]; in_data2 = d[2]; in_data3 = d[3];
        #1;
        nfree  = 12 - $countones(mvalid);
        ready  = (nfree >= 4) && !f;
        fire   = ready && (iv != 4'b0);
        ealloc = '0;
        nd     = mdata;
        for (int i = 0; i < 12; i++) if (!mvalid[i]) fl.push_back(i);
        k = 0;
        if (fire)
            for (int l = 0; l < 4; l++)
                if (iv[l]) begin
                    ealloc[fl[k]] = 1'b1;
                    nd[fl[k]]     = d[l];
                    k++;
                end
        chk("in_ready",   160'(in_ready),   160'(ready));
        chk("alloc_mask", 160'(alloc_mask), 160'(ealloc));
        chk("free_cnt",   160'(free_cnt),   160'(nfree));

        if (r) begin
            nv = '0;
            nd = '0;
        end else if (f) begin
            nv = '0;
            nd = mdata;
        end else begin
            nv = (mvalid & ~g) | ealloc;
        end
        e.valid = nv; e.data = nd; e.chk_all = r;
        sbq.push_back(e);
        mvalid = nv;
        mdata  = nd;

        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("entry_valid", 160'(entry_valid), 160'(e.valid));
        chk("free_cnt_q",  160'(free_cnt),    160'(12 - $countones(e.valid)));
        for (int i = 0; i < 12; i++)
            if (e.valid[i] || e.chk_all) chk($sformatf("entry_data%0d", i), ed[i], e.data[i]);
    endtask

    initial begin
        logic [3:0][159:0] z, d;
        z = '0;
        rst = 1'b1; flush = 1'b0; in_valid = '0; issue_grant = '0;
        in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
        mvalid = '0; mdata = '0;

        step(1'b1, 1'b0, 4'b0000, 12'h000, z);
        step(1'b0, 1'b0, 4'b0000, 12'h000, z);          // reset state: ready=1, free=12
        chk("reset_alloc", 160'(alloc_mask), 160'(12'h000));

        d = {160'hDDDD, 160'hCCCC, 160'hBBBB, 160'hAAAA};
        step(1'b0, 1'b0, 4'b1111, 12'h000, d);
        chk("fill4_valid", 160'(entry_valid), 160'(12'h00F));
        chk("fill4_e3",    ed[3], 160'hDDDD);

        step(1'b0, 1'b0, 4'b0000, 12'h004, z);          // leaves {0,1,3}
        d = {160'h1111, 160'h0, 160'hEEEE, 160'h0};
        step(1'b0, 1'b0, 4'b1010, 12'h000, d);
        chk("compact_e2", ed[2], 160'hEEEE);
        chk("compact_e4", ed[4], 160'h1111);

        d = {rnd160(), rnd160(), rnd160(), rnd160()};
        step(1'b0, 1'b0, 4'b1111, 12'h000, d);          // 9 valid, free=3
        d = {rnd160(), rnd160(), rnd160(), rnd160()};
        step(1'b0, 1'b0, 4'b0001, 12'h001, d);          // not ready, grant entry 0
        step(1'b0, 1'b0, 4'b0000, 12'h000, z);          // free=4, ready=1
        d = {rnd160(), rnd160(), rnd160(), rnd160()};
        step(1'b0, 1'b0, 4'b1111, 12'h000, d);          // full
        chk("full_valid", 160'(entry_valid), 160'(12'hFFF));
        d = {rnd160(), rnd160(), rnd160(), rnd160()};
        step(1'b0, 1'b0, 4'b1111, 12'h801, d);
        step(1'b0, 1'b0, 4'b0000, 12'h000, z);
        chk("after_full_grant", 160'(entry_valid), 160'(12'h7FE));

        d = {rnd160(), rnd160(), rnd160(), rnd160()};
        step(1'b0, 1'b1, 4'b1111, 12'h0F0, d);          // flush wins
        chk("flush_valid", 160'(entry_valid), 160'(12'h000));
        d = {rnd160(), rnd160(), rnd160(), rnd160()};
        step(1'b0, 1'b0, 4'b1111, 12'h000, d);
        d = {rnd160(), rnd160(), rnd160(), rnd160()};
        step(1'b0, 1'b0, 4'b0011, 12'h000, d);          // entries 0..5
        step(1'b0, 1'b0, 4'b0000, 12'h020, z);          // free entry 5
        d = {160'h0, 160'h5555, 160'h0, 160'h0};
        step(1'b0, 1'b0, 4'b0100, 12'h000, d);
        chk("realloc_e5", ed[5], 160'h5555);

        for (int n = 0; n < 40; n++) begin
            d = {rnd160(), rnd160(), rnd160(), rnd160()};
            step(1'b0, ($urandom_range(0, 15) == 0), 4'($urandom), 12'($urandom), d);
        end

        d = {rnd160(), rnd160(), rnd160(), rnd160()};
        step(1'b0, 1'b0, 4'b1111, 12'h000, d);
        d = {rnd160(), rnd160(), rnd160(), rnd160()};
        step(1'b1, 1'b1, 4'b1111, 12'hFFF, d);          // rst beats flush, zeroes data
        step(1'b0, 1'b0, 4'b0000, 12'h000, z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
